uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 16: maximum bytes one requester sends per grant; legal range 1..255.
REQ-002 Parameter HOLD_TIMEOUT, default 8: cycles the owner may leave req_valid low mid-packet before losing the grant; legal range 1..255.
REQ-003 clk  input  1  system clock; every register updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  4  requester i has a byte pending.
REQ-006 req_data  input  32  byte for requester i on bits [8i+7:8i].
REQ-007 req_last  input  4  requester i's pending byte ends its packet.
REQ-008 req_ready  output  4  one-hot, one-cycle pulse: requester i's byte has been consumed.
REQ-009 grant  output  4  one-hot current owner; 0 when no owner.
REQ-010 tx_valid  output  1  byte on tx_data is offered to the UART transmitter core.
REQ-011 tx_data  output  8  byte offered to the transmitter.
REQ-012 tx_ready  input  1  transmitter accepts; a transfer occurs when tx_valid and tx_ready are high at the same rising edge.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The block SHALL use the states IDLE, LOAD, SEND and HOLD, all registered; every output SHALL come directly from a register.
REQ-015 IDLE, any req_valid high: arbitrate round-robin, searching from (last_owner+1) mod 4 upward with wrap; set grant one-hot; clear burst_cnt; go to LOAD.
REQ-016 IDLE, req_valid=0: remain in IDLE with grant=0.
REQ-017 LOAD, req_valid[owner]=1:
- capture tx_data=req_data[owner] and the last flag = req_last[owner];
- pulse req_ready[owner] for exactly one cycle;
- set tx_valid=1;
- increment burst_cnt;
- go to SEND.
REQ-018 LOAD, req_valid[owner]=0: go to HOLD with hold_cnt=0; req_ready and tx_valid SHALL stay 0.
REQ-019 Latency: req_valid sampled high in IDLE at edge n SHALL give req_ready[owner]=1 and tx_valid=1 after edge n+1.
REQ-020 SEND: hold tx_valid and tx_data stable until a transfer.
REQ-021 On a transfer, tx_valid SHALL go to 0 and the next state SHALL be:
- IDLE, if the captured last flag=1 or burst_cnt=MAX_BURST;
- LOAD, otherwise.
REQ-022 When the transfer returns the block to IDLE:
- grant SHALL go to 0;
- last_owner SHALL be updated to the releasing owner.
REQ-023 HOLD, req_valid[owner]=1: go to LOAD.
REQ-024 HOLD, req_valid[owner]=0: increment hold_cnt; when hold_cnt reaches HOLD_TIMEOUT, release as in REQ-022 and go to IDLE.
REQ-025 Requests from non-owners SHALL be ignored while grant is non-zero; no requester SHALL be starved: each waits at most 3 grants.
REQ-026 tx_data SHALL change only in LOAD; tx_valid SHALL never deassert without a transfer, except on rst.
REQ-027 burst_cnt and hold_cnt SHALL be 8 bits wide, saturating, and cleared on each new grant.

Reset
REQ-028 While rst=1 at an edge, the block SHALL set:
- state=IDLE;
- grant=0, req_ready=0, tx_valid=0, tx_data=0x00, busy=0;
- burst_cnt=0, hold_cnt=0;
- last_owner=3, so requester 0 has first priority.
REQ-029 Reset mid-SEND SHALL drop tx_valid after that edge; the byte in flight is discarded and no req_ready pulse is produced for it.

Verification
REQ-030 Single byte: req_valid=0001, req_data[7:0]=0x42, req_last=0001, tx_ready=1 →
- grant=0001;
- tx_data=0x42 with tx_valid 2 cycles after the request;
- exactly one req_ready[0] pulse;
- grant=0 after the transfer.
REQ-031 Round-robin: all four requesters hold single-byte packets (0x10,0x21,0x32,0x43) →
- transfer order 0x10,0x21,0x32,0x43;
- then 0x10 again if requester 0 re-requests.
REQ-032 Backpressure: tx_ready=0 for 20 cycles during SEND → tx_valid=1 and tx_data constant throughout; one transfer when tx_ready rises.
REQ-033 Burst limit: MAX_BURST=4, requester 2 streams 6 bytes with req_last=0 →
- 4 transfers, then grant released;
- the pending requester 3 granted next;
- requester 2 later resumes with its 5th byte.
REQ-034 Hold timeout: owner drops req_valid mid-packet for 9 cycles with HOLD_TIMEOUT=8 →
- grant released after 8 HOLD cycles;
- a waiting requester granted;
- no spurious req_ready.
REQ-035 Reset during SEND with tx_ready=0 →
- tx_valid=0, grant=0, busy=0 after the edge;
- requester 0 granted first afterwards.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets four byte requesters share one UART transmitter.
// Grants are held for one packet, capped at MAX_BURST bytes or HOLD_TIMEOUT idle cycles.
module uart_tx_arbiter #(
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned HOLD_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  req_ready,
    output logic [3:0]  grant,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StLoad, StSend, StHold} state_e;

    state_e      state_q, state_d;
    logic [3:0]  grant_q, grant_d;
    logic [3:0]  req_ready_q, req_ready_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  last_owner_q, last_owner_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        last_flag_q, last_flag_d;
    logic [7:0]  burst_cnt_q, burst_cnt_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic        busy_q, busy_d;

    logic [1:0]  rr_pick;
    logic        rr_found;
    logic [1:0]  rr_cand;
    logic [7:0]  burst_inc;
    logic [7:0]  hold_inc;

    // Search starts one past the previous owner so every requester waits at most 3 grants.
    always_comb begin
        rr_pick  = last_owner_q;
        rr_found = 1'b0;
        rr_cand  = last_owner_q;
        for (int k = 1; k <= 4; k++) begin
            rr_cand = last_owner_q + 2'(k);
            if (!rr_found && req_valid[rr_cand]) begin
                rr_pick  = rr_cand;
                rr_found = 1'b1;
            end
        end
    end

    assign burst_inc = (burst_cnt_q == 8'hFF) ? 8'hFF : burst_cnt_q + 8'd1;
    assign hold_inc  = (hold_cnt_q == 8'hFF) ? 8'hFF : hold_cnt_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        req_ready_d  = 4'b0000;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        tx_valid_d   = tx_valid_q;
        tx_data_d    = tx_data_q;
        last_flag_d  = last_flag_q;
        burst_cnt_d  = burst_cnt_q;
        hold_cnt_d   = hold_cnt_q;

        unique case (state_q)
            StIdle: begin
                grant_d = 4'b0000;
                if (rr_found) begin
                    grant_d     = 4'b0001 << rr_pick;
                    owner_d     = rr_pick;
                    burst_cnt_d = 8'd0;
                    hold_cnt_d  = 8'd0;
                    state_d     = StLoad;
                end
            end
            StLoad: begin
                if (req_valid[owner_q]) begin
                    tx_data_d   = req_data[{owner_q, 3'b000} +: 8];
                    last_flag_d = req_last[owner_q];
                    req_ready_d = grant_q;
                    tx_valid_d  = 1'b1;
                    burst_cnt_d = burst_inc;
                    state_d     = StSend;
                end else begin
                    hold_cnt_d = 8'd0;
                    state_d    = StHold;
                end
            end
            StSend: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (last_flag_q || burst_cnt_q >= 8'(MAX_BURST)) begin
                        grant_d      = 4'b0000;
                        last_owner_d = owner_q;
                        state_d      = StIdle;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StHold: begin
                if (req_valid[owner_q]) begin
                    state_d = StLoad;
                end else begin
                    hold_cnt_d = hold_inc;
                    if (hold_inc >= 8'(HOLD_TIMEOUT)) begin
                        grant_d      = 4'b0000;
                        last_owner_d = owner_q;
                        state_d      = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= 4'b0000;
            req_ready_q  <= 4'b0000;
            owner_q      <= 2'd0;
            last_owner_q <= 2'd3;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            last_flag_q  <= 1'b0;
            burst_cnt_q  <= 8'd0;
            hold_cnt_q   <= 8'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            req_ready_q  <= req_ready_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            last_flag_q  <= last_flag_d;
            burst_cnt_q  <= burst_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            busy_q       <= busy_d;
        end
    end

    assign grant     = grant_q;
    assign req_ready = req_ready_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign busy      = busy_q;

endmodule
